// File: rtl/apb_mst_pkg.sv
// Types and constants for the single-requester APB initiator.
package apb_mst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_mst_state_e;

  // Read data returned when the watchdog terminates a transfer.
  localparam logic [31:0] APB_MST_TIMEOUT_RDATA = 32'hFFFF_FFFF;

  // Every bit the initiator remembers between cycles, including the
  // registered copies of the handshake/APB control outputs. The watchdog
  // counter lives beside this struct because its width follows the
  // module's timeout parameter.
  typedef struct packed {
    apb_mst_state_e state;
    logic [31:0]    addr;
    logic           write;
    logic [31:0]    wdata;
    logic [3:0]     wstrb;
    logic [31:0]    rdata;
    logic           err;
    logic           psel;
    logic           penable;
    logic           req_ready;
    logic           resp_valid;
  } apb_mst_registers;

  localparam apb_mst_registers apb_mst_r_reset = '{
    state:      ST_IDLE,
    addr:       32'h0000_0000,
    write:      1'b0,
    wdata:      32'h0000_0000,
    wstrb:      4'h0,
    rdata:      32'h0000_0000,
    err:        1'b0,
    psel:       1'b0,
    penable:    1'b0,
    req_ready:  1'b1,
    resp_valid: 1'b0
  };

  // Watchdog counter width; at least one bit so a disabled watchdog
  // (timeout of 0) still yields a legal vector.
  function automatic int unsigned apb_mst_wdog_width(input int unsigned t);
    int unsigned w;
    w = $clog2(t + 32'd1);
    if (w == 32'd0) begin
      w = 32'd1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/types_amba_pkg.sv
// AMBA APB bus types shared by initiators and slaves: request toward the
// slave (apb_in_type) and response from the slave (apb_out_type).
package types_amba_pkg;

  typedef struct packed {
    logic        pselx;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_in_type;

  localparam apb_in_type apb_in_none = '{
    pselx:   1'b0,
    penable: 1'b0,
    paddr:   32'h0000_0000,
    pwrite:  1'b0,
    pwdata:  32'h0000_0000,
    pstrb:   4'h0,
    pprot:   3'b000
  };

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_out_type;

  localparam apb_out_type apb_out_none = '{
    pready:  1'b0,
    prdata:  32'h0000_0000,
    pslverr: 1'b0
  };

endpackage

// File: rtl/apb_mst.sv
// Single-requester APB initiator: turns a valid/ready request into one
// SETUP + ACCESS transfer, returns the result on a valid/ready response
// channel, and aborts with an error if the slave never raises pready.
module apb_mst
  import apb_mst_pkg::*;
  import types_amba_pkg::*;
#(
  parameter int unsigned timeout_cycles = 1024
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wstrb,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output apb_in_type  o_apbi,
  input  apb_out_type i_apbo
);

  localparam int unsigned      CNT_W    = apb_mst_wdog_width(timeout_cycles);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = (timeout_cycles == 32'd0) ? CNT_W'(0)
                                                                     : CNT_W'(timeout_cycles - 32'd1);
  localparam logic             WDOG_ON  = (timeout_cycles != 32'd0);

  apb_mst_registers r_q;
  apb_mst_registers w_v;
  logic [CNT_W-1:0] r_wdog_cnt;
  logic [CNT_W-1:0] w_wdog_cnt;

  // Next-state logic: sequences IDLE -> SETUP -> ACCESS -> RESP and the watchdog
  always_comb begin
    w_v        = r_q;
    w_wdog_cnt = r_wdog_cnt;
    case (r_q.state)
      ST_IDLE: begin
        if (i_req_valid) begin
          w_v.addr      = i_req_addr;
          w_v.write     = i_req_write;
          w_v.wdata     = i_req_wdata;
          w_v.wstrb     = i_req_write ? i_req_wstrb : 4'h0;
          w_v.psel      = 1'b1;
          w_v.penable   = 1'b0;
          w_v.req_ready = 1'b0;
          w_v.state     = ST_SETUP;
        end else begin
          w_v.req_ready = 1'b1;
        end
      end
      ST_SETUP: begin
        w_v.penable = 1'b1;
        w_v.state   = ST_ACCESS;
        w_wdog_cnt  = '0;
      end
      ST_ACCESS: begin
        // pready has priority over an expiring watchdog in the same cycle
        if (i_apbo.pready) begin
          w_v.rdata      = r_q.write ? 32'h0000_0000 : i_apbo.prdata;
          w_v.err        = i_apbo.pslverr;
          w_v.psel       = 1'b0;
          w_v.penable    = 1'b0;
          w_v.resp_valid = 1'b1;
          w_v.state      = ST_RESP;
        end else if (WDOG_ON && (r_wdog_cnt == CNT_LAST)) begin
          w_v.rdata      = APB_MST_TIMEOUT_RDATA;
          w_v.err        = 1'b1;
          w_v.psel       = 1'b0;
          w_v.penable    = 1'b0;
          w_v.resp_valid = 1'b1;
          w_v.state      = ST_RESP;
        end else if (r_wdog_cnt != CNT_MAX) begin
          w_wdog_cnt = r_wdog_cnt + CNT_ONE;
        end else begin
          w_wdog_cnt = r_wdog_cnt;
        end
      end
      ST_RESP: begin
        if (i_resp_ready) begin
          w_v.resp_valid = 1'b0;
          w_v.req_ready  = 1'b1;
          w_v.state      = ST_IDLE;
        end else begin
          w_v.resp_valid = 1'b1;
        end
      end
      default: begin
        w_v        = apb_mst_r_reset;
        w_wdog_cnt = '0;
      end
    endcase
  end

  // State registers; reset drops the APB select immediately without a response
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_q        <= apb_mst_r_reset;
      r_wdog_cnt <= '0;
    end else begin
      r_q        <= w_v;
      r_wdog_cnt <= w_wdog_cnt;
    end
  end

  assign o_apbi = '{
    pselx:   r_q.psel,
    penable: r_q.penable,
    paddr:   r_q.addr,
    pwrite:  r_q.write,
    pwdata:  r_q.wdata,
    pstrb:   r_q.wstrb,
    pprot:   3'b000
  };

  assign o_req_ready  = r_q.req_ready;
  assign o_resp_valid = r_q.resp_valid;
  assign o_resp_rdata = r_q.rdata;
  assign o_resp_err   = r_q.err;

endmodule

// File: tb/tb_apb_mst.sv
// Bench for apb_mst: a directed sequence followed by random transfers, each
// checked cycle by cycle against a transfer-level reference (ACCESS length,
// returned data and error derived from wait count, direction and timeout).
module tb_apb_mst;
  import types_amba_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = 32'h0;
  logic        req_write = 1'b0;
  logic [31:0] req_wdata = 32'h0;
  logic [3:0]  req_wstrb = 4'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  apb_in_type  apbi;
  apb_out_type apbo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  apb_mst #(.timeout_cycles(T)) dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_addr   (req_addr),
    .i_req_write  (req_write),
    .i_req_wdata  (req_wdata),
    .i_req_wstrb  (req_wstrb),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_apbi       (apbi),
    .i_apbo       (apbo)
  );

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Slave outputs that must be ignored outside ACCESS: pready high plus noise.
  task automatic slave_noise();
    apbo.pready  = 1'b1;
    apbo.prdata  = $urandom;
    apbo.pslverr = 1'($urandom);
  endtask

  // One full transfer driven from a negedge in Idle; returns at the negedge
  // after the response handshake. 'pend' keeps a different request valid
  // while this one is in flight.
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int waits, input logic [31:0] prdata,
                      input logic slverr, input int resp_hold, input bit pend);
    int          acc;
    logic [31:0] e_rdata;
    logic        e_err;
    logic [3:0]  e_strb;
    if (waits >= T) begin
      acc = T; e_rdata = 32'hFFFF_FFFF; e_err = 1'b1;
    end else begin
      acc = waits + 1; e_rdata = wr ? 32'h0 : prdata; e_err = slverr;
    end
    e_strb = wr ? strb : 4'h0;

    chk1("idle_req_ready", req_ready, 1'b1);
    chk1("idle_resp_valid", resp_valid, 1'b0);
    req_valid = 1'b1; req_addr = addr; req_write = wr; req_wdata = wdata; req_wstrb = strb;
    slave_noise();
    @(posedge clk); @(negedge clk);

    if (pend) begin
      req_addr = ~addr; req_write = ~wr; req_wdata = ~wdata; req_wstrb = ~strb;
    end else begin
      req_valid = 1'b0;
    end
    chk1("setup_psel", apbi.pselx, 1'b1);
    chk1("setup_penable", apbi.penable, 1'b0);
    chk32("setup_paddr", apbi.paddr, addr);
    chk1("setup_pwrite", apbi.pwrite, wr);
    chk32("setup_pwdata", apbi.pwdata, wdata);
    chk32("setup_pstrb", 32'(apbi.pstrb), 32'(e_strb));
    chk32("setup_pprot", 32'(apbi.pprot), 32'h0);
    chk1("setup_req_ready", req_ready, 1'b0);
    chk1("setup_resp_valid", resp_valid, 1'b0);
    slave_noise();
    @(posedge clk); @(negedge clk);

    for (int k = 0; k < acc; k++) begin
      chk1("access_psel", apbi.pselx, 1'b1);
      chk1("access_penable", apbi.penable, 1'b1);
      chk32("access_paddr", apbi.paddr, addr);
      chk32("access_pwdata", apbi.pwdata, wdata);
      chk32("access_pstrb", 32'(apbi.pstrb), 32'(e_strb));
      chk1("access_req_ready", req_ready, 1'b0);
      chk1("access_resp_valid", resp_valid, 1'b0);
      if (k == waits) begin
        apbo.pready = 1'b1; apbo.prdata = prdata; apbo.pslverr = slverr;
      end else begin
        apbo.pready = 1'b0; apbo.prdata = $urandom; apbo.pslverr = 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
    end

    slave_noise();
    for (int h = 0; h <= resp_hold; h++) begin
      chk1("resp_valid", resp_valid, 1'b1);
      chk32("resp_rdata", resp_rdata, e_rdata);
      chk1("resp_err", resp_err, e_err);
      chk1("resp_psel", apbi.pselx, 1'b0);
      chk1("resp_penable", apbi.penable, 1'b0);
      chk1("resp_req_ready", req_ready, 1'b0);
      resp_ready = (h == resp_hold);
      @(posedge clk); @(negedge clk);
    end
    resp_ready = 1'b0;
    chk1("post_resp_valid", resp_valid, 1'b0);
    chk1("post_req_ready", req_ready, 1'b1);
    chk1("post_psel", apbi.pselx, 1'b0);
  endtask

  initial begin
    apbo = '0;
    #12;
    chk1("rst_psel", apbi.pselx, 1'b0);
    chk1("rst_penable", apbi.penable, 1'b0);
    chk32("rst_paddr", apbi.paddr, 32'h0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk32("rst_rdata", resp_rdata, 32'h0);
    chk1("rst_err", resp_err, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // 0-wait write
    xfer(32'h0000_1004, 1'b1, 32'hA5A5_5A5A, 4'hF, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    // read with 3 wait states
    xfer(32'h0000_2000, 1'b0, 32'h0000_0000, 4'hF, 3, 32'h1234_5678, 1'b0, 0, 1'b0);
    // read with slave error
    xfer(32'h0000_3008, 1'b0, 32'h1111_2222, 4'h3, 1, 32'hCAFE_F00D, 1'b1, 2, 1'b0);
    // slave never ready -> watchdog
    xfer(32'h0000_4000, 1'b0, 32'h0, 4'h0, 1000, 32'h0, 1'b0, 0, 1'b0);
    // last wait before the watchdog fires
    xfer(32'h0000_4004, 1'b0, 32'h0, 4'h0, T - 1, 32'h7777_8888, 1'b0, 0, 1'b0);
    // response held 5 cycles with a second request pending, then that one runs
    xfer(32'h0000_5000, 1'b1, 32'h0BAD_F00D, 4'h5, 2, 32'h0, 1'b0, 5, 1'b1);
    xfer(~32'h0000_5000, 1'b0, ~32'h0BAD_F00D, ~4'h5, 0, 32'h5555_AAAA, 1'b0, 0, 1'b0);

    // reset in the middle of ACCESS
    req_valid = 1'b1; req_addr = 32'h0000_6000; req_write = 1'b1;
    req_wdata = 32'h6666_6666; req_wstrb = 4'hF; apbo = '0;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk1("pre_rst_penable", apbi.penable, 1'b1);
    #2 nrst = 1'b0;
    #1;
    chk1("async_rst_psel", apbi.pselx, 1'b0);
    chk1("async_rst_penable", apbi.penable, 1'b0);
    chk32("async_rst_paddr", apbi.paddr, 32'h0);
    chk1("async_rst_resp_valid", resp_valid, 1'b0);
    chk1("async_rst_req_ready", req_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      chk1("after_rst_resp_valid", resp_valid, 1'b0);
      chk1("after_rst_psel", apbi.pselx, 1'b0);
    end
    xfer(32'h0000_7000, 1'b0, 32'h0, 4'h0, 1, 32'h0F0F_F0F0, 1'b0, 0, 1'b0);

    // random transfers
    for (int n = 0; n < 24; n++) begin
      xfer($urandom, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 10),
           $urandom, 1'($urandom), $urandom_range(0, 3), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
